exins_server: RTL
=================

EXINS_SERVER -- requirements
Module: exins_server

Interface
REQ-001 Parameter EXT_SIZE, default 32'h0000_1000: byte size of the external instruction space; word addresses at or above EXT_SIZE are out of range.
REQ-002 Parameter NOP_WORD, default 32'h0000_0013: word returned for any out-of-range fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 exIns_ren  input  1  fetch request from the instruction-fetch unit; held high while the fetch unit waits.
REQ-006 exIns_addr  input  32  byte address of the requested instruction; bits [1:0] ignored; 32'hffff_ffff when idle.
REQ-007 exIns_valid  output  1  exIns_in holds the word for the current exIns_addr this cycle.
REQ-008 exIns_in  output  32  instruction word, little-endian assembly of four ROM bytes.
REQ-009 rom_req  output  1  byte read request to the external byte-wide ROM.
REQ-010 rom_addr  output  32  ROM byte address, equal to {word address, byte index[1:0]}.
REQ-011 rom_ack  input  1  ROM has placed a valid byte on rom_data this cycle.
REQ-012 rom_data  input  8  ROM read data, sampled only when rom_req & rom_ack.

Function
REQ-013 The block SHALL hold a one-entry line buffer: tag_v (1 bit), tag (30 bits, word address), line (32 bits).
REQ-014 exIns_valid SHALL be combinational: exIns_ren & tag_v & (tag == exIns_addr[31:2]); exIns_in SHALL equal line at all times.
REQ-015 A hit SHALL therefore return data in the same cycle as the request (zero added latency); no state changes on a hit.
REQ-016 FSM states: IDLE, FILL, DONE.
REQ-017 IDLE -> FILL when exIns_ren is high and the request misses and exIns_addr < EXT_SIZE; pend_tag <= exIns_addr[31:2], byte_cnt <= 0, tag_v <= 0.
REQ-018 IDLE, out-of-range miss: line <= NOP_WORD, tag <= exIns_addr[31:2], tag_v <= 1 next cycle; no ROM traffic; state stays IDLE.
REQ-019 FILL: rom_req = 1, rom_addr = {pend_tag, byte_cnt}; on rom_req & rom_ack, line byte[byte_cnt] <= rom_data and byte_cnt increments.
REQ-020 rom_req SHALL stay high across consecutive bytes; rom_addr changes only in the cycle after an ack.
REQ-021 On the ack of byte 3, if pend_tag still equals exIns_addr[31:2] and exIns_ren is high, tag <= pend_tag, tag_v <= 1, state -> DONE; the hit in DONE raises exIns_valid, so fill-to-valid latency is 1 cycle after the last ack.
REQ-022 Abort: at any ack in FILL where exIns_ren is low or exIns_addr[31:2] != pend_tag (branch redirect), the captured byte SHALL be discarded, tag_v stays 0, state -> IDLE; no abort occurs between acks (an outstanding request is never withdrawn).
REQ-023 DONE -> IDLE unconditionally after one cycle; rom_req = 0 in IDLE and DONE.
REQ-024 A redirect to a new address re-enters FILL from IDLE on the following cycle; minimum miss latency SHALL be 4 acks + 2 cycles.
REQ-025 byte_cnt SHALL be 2 bits and wrap 3 -> 0 only on FILL exit; pend_tag + byte_cnt SHALL never carry into bit 2.
REQ-026 exIns_ren low with a stale address SHALL never produce exIns_valid.

Reset
REQ-027 With rst high at a clock edge: state IDLE, tag_v 0, tag 0, line 0, pend_tag 0, byte_cnt 0; hence exIns_valid 0, exIns_in 0, rom_req 0, rom_addr 0.
REQ-028 rst asserted during FILL SHALL abandon the fill immediately; rom_req is 0 in the cycle after the reset edge regardless of rom_ack.
REQ-029 rst SHALL dominate all other inputs in the same cycle.

Verification
REQ-030 Cold miss: ren=1, addr=0x0000_0010, ROM bytes 13,00,00,00 acked one per cycle -> rom_addr 0x10,0x11,0x12,0x13; exIns_valid=1 with exIns_in=0x0000_0013 one cycle after 4th ack.
REQ-031 Hit: repeat addr 0x0000_0012 immediately after -> exIns_valid=1 same cycle, rom_req stays 0.
REQ-032 Redirect: during fill of 0x20 change addr to 0x40 after 2nd ack -> fill aborts at 3rd ack, new fill with rom_addr 0x40; no valid for 0x20.
REQ-033 Out of range: addr=0x0000_1000 -> no rom_req, exIns_valid=1 with exIns_in=0x0000_0013 next cycle.
REQ-034 ROM stall: rom_ack held low 5 cycles per byte -> rom_req and rom_addr stable throughout; valid after last ack + 1.
REQ-035 Reset mid-fill after 1st ack -> rom_req 0, exIns_valid 0 next cycle; re-request refetches from byte 0.

Source files
------------

// File: rtl/exins_server.sv
// -----------------------------------------------------------------------------
// exins_server
//
// Serves 32-bit instruction fetches from a byte-wide external ROM through a
// single-entry line buffer. A hit answers in the same cycle. A miss inside the
// external space fills the line one byte per ROM ack. A miss outside that
// space loads NOP_WORD without any ROM traffic.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   exIns_ren    fetch request, held high while the fetch unit waits
//   exIns_addr   requested byte address (bits [1:0] ignored)
//   exIns_valid  exIns_in holds the word for exIns_addr this cycle
//   exIns_in     line buffer contents (little-endian word)
//   rom_req      byte read request to the ROM
//   rom_addr     ROM byte address {word address, byte index}
//   rom_ack      ROM data valid this cycle
//   rom_data     ROM byte, sampled on rom_req & rom_ack
// -----------------------------------------------------------------------------
module exins_server #(
  parameter logic [31:0] EXT_SIZE = 32'h0000_1000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exIns_ren,
  input  logic [31:0] exIns_addr,
  output logic        exIns_valid,
  output logic [31:0] exIns_in,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        tag_v_q, tag_v_d;
  logic [29:0] tag_q, tag_d;
  logic [31:0] line_q, line_d;
  logic [29:0] pend_tag_q, pend_tag_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  logic [29:0] req_tag;
  logic        hit;
  logic        in_range;
  logic        redirect;
  logic        unused_addr_bits;

  assign req_tag          = exIns_addr[31:2];
  assign unused_addr_bits = ^exIns_addr[1:0];

  // Range test on the word-aligned address so a partial-word offset never
  // pulls the last word of the space out of range.
  assign in_range = ({req_tag, 2'b00} < EXT_SIZE);

  assign hit      = exIns_ren & tag_v_q & (tag_q == req_tag);

  // The fetch unit has moved on (dropped the request or branched); only
  // acted upon at an ack so an issued ROM read is never withdrawn.
  assign redirect = ~exIns_ren | (req_tag != pend_tag_q);

  assign exIns_valid = hit;
  assign exIns_in    = line_q;
  assign rom_req     = (state_q == S_FILL);
  // Byte index occupies the low two bits; pend_tag is a word address so the
  // concatenation can never carry into the tag.
  assign rom_addr    = {pend_tag_q, byte_cnt_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tag_v_q    <= 1'b0;
      tag_q      <= '0;
      line_q     <= '0;
      pend_tag_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tag_v_q    <= tag_v_d;
      tag_q      <= tag_d;
      line_q     <= line_d;
      pend_tag_q <= pend_tag_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tag_v_d    = tag_v_q;
    tag_d      = tag_q;
    line_d     = line_q;
    pend_tag_d = pend_tag_q;
    byte_cnt_d = byte_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (exIns_ren && !hit) begin
          if (in_range) begin
            state_d    = S_FILL;
            pend_tag_d = req_tag;
            byte_cnt_d = 2'd0;
            tag_v_d    = 1'b0;
          end else begin
            // Out-of-range fetch: synthesize a NOP line, no ROM access.
            line_d  = NOP_WORD;
            tag_d   = req_tag;
            tag_v_d = 1'b1;
          end
        end
      end

      S_FILL: begin
        if (rom_ack) begin
          if (redirect) begin
            // Drop the byte; the line is left invalid and IDLE re-evaluates
            // the new request on the next cycle.
            state_d    = S_IDLE;
            byte_cnt_d = 2'd0;
          end else begin
            line_d[{byte_cnt_q, 3'b000} +: 8] = rom_data;
            // Two-bit counter wraps to 0 exactly when the fill completes.
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              tag_d   = pend_tag_q;
              tag_v_d = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end

      // One settling cycle in which the freshly filled line is presented.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

endmodule
